// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// One operation per Start; shift-add multiply or restoring divide over
// D_WIDTH iterations, framed by one PREP and one FIX cycle. The result is
// registered and announced with a one-cycle Done pulse.
module muldiv_unit #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [2:0]         MulDivControl,
  input  logic [D_WIDTH-1:0] SrcA,
  input  logic [D_WIDTH-1:0] SrcB,
  input  logic               Flush,
  output logic               Busy,
  output logic               Done,
  output logic [D_WIDTH-1:0] MulDivResult
);

  localparam int CNT_W = $clog2(D_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;

  // Operation captured at launch
  logic [2:0]               op_q;
  logic [D_WIDTH-1:0]       a_q;
  logic [D_WIDTH-1:0]       b_q;

  // Working registers: operand signs, divisor/multiplicand magnitude and the
  // double-width accumulator (upper half = partial product / remainder,
  // lower half = multiplier / dividend shifting into quotient).
  logic                     sa_q;
  logic                     sb_q;
  logic [D_WIDTH-1:0]       mag_b;
  logic [2*D_WIDTH-1:0]     acc;

  logic                     is_div;
  logic                     signed_a;
  logic                     signed_b;
  logic [D_WIDTH:0]         mul_sum;
  logic [2*D_WIDTH-1:0]     mul_next;
  logic [D_WIDTH:0]         div_trial;
  logic [D_WIDTH-1:0]       div_diff;
  logic                     div_ge;
  logic [2*D_WIDTH-1:0]     div_next;
  logic [2*D_WIDTH-1:0]     prod;
  logic [D_WIDTH-1:0]       quo;
  logic [D_WIDTH-1:0]       remv;
  logic                     div_zero;
  logic [D_WIDTH-1:0]       fix_result;

  // Two's-complement sign correction, single and double width
  function automatic logic [D_WIDTH-1:0] cond_neg(input logic [D_WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*D_WIDTH-1:0] cond_neg_wide(input logic [2*D_WIDTH-1:0] v,
                                                         input logic neg);
    return neg ? -v : v;
  endfunction

  assign is_div = op_q[2];

  // Operand signedness decoded from funct3
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (op_q)
      3'b001, 3'b100, 3'b110: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'b010: signed_a = 1'b1;
      default: begin
        signed_a = 1'b0;
        signed_b = 1'b0;
      end
    endcase
  end

  // One iteration step for both algorithms
  always_comb begin
    mul_sum   = {1'b0, acc[2*D_WIDTH-1:D_WIDTH]} + {1'b0, mag_b};
    mul_next  = acc[0] ? {mul_sum, acc[D_WIDTH-1:1]}
                       : {1'b0, acc[2*D_WIDTH-1:1]};
    // Remainder shifted left with the next dividend bit; needs one extra bit
    // because the remainder can be as large as divisor-1.
    div_trial = acc[2*D_WIDTH-1:D_WIDTH-1];
    div_ge    = div_trial >= {1'b0, mag_b};
    div_diff  = div_trial[D_WIDTH-1:0] - mag_b;
    div_next  = div_ge ? {div_diff, acc[D_WIDTH-2:0], 1'b1}
                       : {div_trial[D_WIDTH-1:0], acc[D_WIDTH-2:0], 1'b0};
  end

  // Final sign correction, result selection and divide special cases
  always_comb begin
    prod       = cond_neg_wide(acc, sa_q ^ sb_q);
    quo        = cond_neg(acc[D_WIDTH-1:0], sa_q ^ sb_q);
    remv       = cond_neg(acc[2*D_WIDTH-1:D_WIDTH], sa_q);
    div_zero   = (b_q == '0);
    fix_result = '0;
    case (op_q)
      3'b000:                 fix_result = prod[D_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod[2*D_WIDTH-1:D_WIDTH];
      3'b100, 3'b101:         fix_result = div_zero ? '1 : quo;
      default:                fix_result = div_zero ? a_q : remv;
    endcase
  end

  // Control sequencing, status outputs and the result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      MulDivResult <= '0;
    end else if (Flush) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= PREP;
            Busy  <= 1'b1;
          end
        end
        PREP: begin
          state <= ITER;
          cnt   <= '0;
        end
        ITER: begin
          if (cnt == CNT_LAST) begin
            state <= FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          state        <= IDLE;
          Busy         <= 1'b0;
          Done         <= 1'b1;
          MulDivResult <= fix_result;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: capture, magnitude preparation and iteration
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (Start) begin
          op_q <= MulDivControl;
          a_q  <= SrcA;
          b_q  <= SrcB;
        end
      end
      PREP: begin
        sa_q  <= signed_a & a_q[D_WIDTH-1];
        sb_q  <= signed_b & b_q[D_WIDTH-1];
        mag_b <= cond_neg(b_q, signed_b & b_q[D_WIDTH-1]);
        acc   <= {{D_WIDTH{1'b0}}, cond_neg(a_q, signed_a & a_q[D_WIDTH-1])};
      end
      ITER: begin
        acc <= is_div ? div_next : mul_next;
      end
      default: begin
        acc <= acc;
      end
    endcase
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the combinational ALU in the execute stage of the pipelined core. It accepts one operation per Start pulse, runs a fixed-latency shift-add (multiply) or restoring (divide) sequence, and returns a registered result with a one-cycle Done pulse. The execute stage stalls on Busy.

## Interface
- D_WIDTH, 32, operand/result width; sequencing and special-case rules are specified for 32
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low; the only clock is clk
- Start  input  1  launch request, sampled only in IDLE
- MulDivControl  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  D_WIDTH  rs1 operand / dividend, sampled with Start
- SrcB  input  D_WIDTH  rs2 operand / divisor, sampled with Start
- Flush  input  1  abort current operation (branch mispredict / trap)
- Busy  output  1  operation in progress; Start ignored while high
- Done  output  1  one-cycle pulse; MulDivResult valid this cycle
- MulDivResult  output  D_WIDTH  registered result, held until next Done

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE: Start=1 and Flush=0 at an edge → latch SrcA, SrcB, MulDivControl → PREP.
- PREP (1 cycle): record result sign; take absolute values for signed operands (MULH/DIV/REM: both signed; MULHSU: SrcA only); clear 2·D_WIDTH accumulator and iteration counter → ITER.
- ITER (exactly D_WIDTH cycles):
  - Multiply: per cycle, if multiplier LSB=1, add multiplicand into accumulator upper half; shift right 1.
  - Divide: per cycle, shift remainder left with next dividend bit; if remainder ≥ divisor, subtract and set quotient bit to 1.
  - Counter wraps D_WIDTH-1 → FIX.
- FIX (1 cycle): apply two's-complement sign correction; select low half (MUL), high half (MULH/MULHSU/MULHU), quotient or remainder; register MulDivResult, Done=1 next cycle; → IDLE.
- Divide special cases, same fixed latency:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → SrcA.
  - DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - Remainder sign follows dividend; quotient sign = XOR of operand signs.
- Flush=1 at any edge → IDLE; no Done; MulDivResult unchanged. Flush wins over simultaneous Start.
- Start while Busy=1: ignored, no queuing.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, Busy=0, Done=0, MulDivResult=0, counter=0. Reset mid-operation discards it; no Done.
- Start sampled at edge E0 → Busy=1 from after E0 → Done=1 and new MulDivResult in the cycle after edge E0+D_WIDTH+2 (34 for 32-bit).
- Busy=0 in the Done cycle; a Start in the Done cycle is accepted (back-to-back, one op per 35 cycles).
- Done is high for exactly one cycle; MulDivResult is stable from that cycle until the next Done.
- No combinational path from any input to any output.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-DIV → Busy=0, Done=0, MulDivResult=0; no Done afterwards.
- MUL/MULH/MULHU/MULHSU with SrcA=0xFFFFFFFF, SrcB=0x00000002 → 0xFFFFFFFE / 0xFFFFFFFF / 0x00000001 / 0xFFFFFFFF; Done exactly 34 cycles after Start edge.
- DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 7/2 → 3; REMU → 1.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF; REM 0x1234/0 → 0x1234. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; latency unchanged.
- Flush at ITER cycle 10 with simultaneous Start → no Done, returns to IDLE, MulDivResult keeps its previous value; the next Start completes normally.
- Back-to-back: Start held high continuously, second Start in first Done cycle → second Done 35 cycles after the first; Start pulses while Busy=1 do not alter the result.
